// File: rtl/vtmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vtmem_arbiter
// Description : Time-slices the single-port 2Kx16 KSM controller RAM between
//               the Wishbone CPU port and the video refresh fetch port. Every
//               RAM access occupies an issue slot (RAM strobes driven) and a
//               done slot (registered read data visible, acknowledge given).
//               Contention is resolved round-robin. A requester that has just
//               been served is never a candidate at the edge ending its own
//               done slot, because its request line is still high there.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW          RAM word-address width
//   VID_FIRST   1: video wins the first contention after reset; 0: CPU wins
// Ports
//   wb_clk_i, wb_rst_i   clock; synchronous active-high reset
//   wb_cyc_i, wb_stb_i   Wishbone cycle / strobe (request = cyc & stb)
//   wb_we_i, wb_sel_i    write enable, byte selects ([1] = high byte)
//   wb_adr_i, wb_dat_i   word address, write data
//   wb_dat_o, wb_ack_o   read data (valid with ack), one-cycle acknowledge
//   vid_req, vid_adr     video fetch request (level) and address
//   vid_dat, vid_ack     fetched word (valid with ack), one-cycle acknowledge
//   ram_address/byteena/data/rden/wren   registered RAM controls
//   ram_q                RAM read data, valid one cycle after ram_rden
// ============================================================================
module vtmem_arbiter #(
  parameter int AW        = 11,
  parameter bit VID_FIRST = 1'b1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_sel_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [15:0]   wb_dat_i,
  output logic [15:0]   wb_dat_o,
  output logic          wb_ack_o,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  output logic [15:0]   vid_dat,
  output logic          vid_ack,
  output logic [AW-1:0] ram_address,
  output logic [1:0]    ram_byteena,
  output logic [15:0]   ram_data,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [15:0]   ram_q
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_ISS_V  = 3'd1;
  localparam logic [2:0] c_ST_ISS_CR = 3'd2;
  localparam logic [2:0] c_ST_ISS_CW = 3'd3;
  localparam logic [2:0] c_ST_DONE_V = 3'd4;
  localparam logic [2:0] c_ST_DONE_C = 3'd5;

  // last_grant values: who was served most recently
  localparam logic c_LG_CPU = 1'b0;
  localparam logic c_LG_VID = 1'b1;
  // Reset to the loser of the first contention so VID_FIRST's choice wins it
  localparam logic c_LG_RST = VID_FIRST ? c_LG_CPU : c_LG_VID;

  logic [2:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;

  logic          w_cpu_req;
  logic          w_cand_v, w_cand_c;
  logic          w_grant_v, w_grant_c;

  logic [AW-1:0] ram_address_q, ram_address_d;
  logic [1:0]    ram_byteena_q, ram_byteena_d;
  logic [15:0]   ram_data_q, ram_data_d;
  logic          ram_rden_q, ram_rden_d;
  logic          ram_wren_q, ram_wren_d;

  assign w_cpu_req = wb_cyc_i & wb_stb_i;

  // --------------------------------------------------------------------------
  // Grant candidates. Decisions are only made at the edge ending IDLE or a
  // DONE slot; in a DONE slot the requester just served is excluded because
  // its request is still asserted while its acknowledge is visible.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cand_v = 1'b0;
    w_cand_c = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        w_cand_v = vid_req;
        w_cand_c = w_cpu_req;
      end
      c_ST_DONE_V: w_cand_c = w_cpu_req;
      c_ST_DONE_C: w_cand_v = vid_req;
      default: begin
        w_cand_v = 1'b0;
        w_cand_c = 1'b0;
      end
    endcase
  end

  // Round-robin: on contention serve whoever was not served last.
  // Contention can only occur in IDLE; DONE slots offer a single candidate.
  always_comb begin
    w_grant_v = 1'b0;
    w_grant_c = 1'b0;
    if (w_cand_v && w_cand_c) begin
      if (last_grant_q == c_LG_VID) begin
        w_grant_c = 1'b1;
      end else begin
        w_grant_v = 1'b1;
      end
    end else begin
      w_grant_v = w_cand_v;
      w_grant_c = w_cand_c;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= c_ST_IDLE;
      last_grant_q <= c_LG_RST;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      c_ST_IDLE, c_ST_DONE_V, c_ST_DONE_C: begin
        if (w_grant_v) begin
          state_d      = c_ST_ISS_V;
          last_grant_d = c_LG_VID;
        end else if (w_grant_c) begin
          state_d      = wb_we_i ? c_ST_ISS_CW : c_ST_ISS_CR;
          last_grant_d = c_LG_CPU;
        end else begin
          state_d      = c_ST_IDLE;
        end
      end
      c_ST_ISS_V:               state_d = c_ST_DONE_V;
      c_ST_ISS_CR, c_ST_ISS_CW: state_d = c_ST_DONE_C;
      default:                  state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Acknowledges decode the current state. RAM controls are
  // decoded from the next state and registered, so they are valid throughout
  // the issue slot and return to zero in every other slot.
  // --------------------------------------------------------------------------
  always_comb begin
    // An aborted CPU cycle (cyc or stb low in DONE_C) gets no acknowledge
    wb_ack_o      = (state_q == c_ST_DONE_C) && w_cpu_req;
    vid_ack       = (state_q == c_ST_DONE_V);

    ram_address_d = '0;
    ram_byteena_d = 2'b00;
    ram_data_d    = 16'h0000;
    ram_rden_d    = 1'b0;
    ram_wren_d    = 1'b0;
    case (state_d)
      c_ST_ISS_V: begin
        ram_address_d = vid_adr;
        ram_rden_d    = 1'b1;
      end
      c_ST_ISS_CR: begin
        ram_address_d = wb_adr_i;
        ram_byteena_d = 2'b11;
        ram_rden_d    = 1'b1;
      end
      c_ST_ISS_CW: begin
        // sel = 00 still takes a full slot; the RAM simply writes no byte
        ram_address_d = wb_adr_i;
        ram_byteena_d = wb_sel_i;
        ram_data_d    = wb_dat_i;
        ram_wren_d    = 1'b1;
      end
      default: begin
        ram_address_d = '0;
        ram_byteena_d = 2'b00;
        ram_data_d    = 16'h0000;
        ram_rden_d    = 1'b0;
        ram_wren_d    = 1'b0;
      end
    endcase
  end

  // RAM control registers. A write whose issue slot ends on the reset edge
  // has already been presented to the RAM and is committed there.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ram_address_q <= '0;
      ram_byteena_q <= 2'b00;
      ram_data_q    <= 16'h0000;
      ram_rden_q    <= 1'b0;
      ram_wren_q    <= 1'b0;
    end else begin
      ram_address_q <= ram_address_d;
      ram_byteena_q <= ram_byteena_d;
      ram_data_q    <= ram_data_d;
      ram_rden_q    <= ram_rden_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_byteena = ram_byteena_q;
  assign ram_data    = ram_data_q;
  assign ram_rden    = ram_rden_q;
  assign ram_wren    = ram_wren_q;

  // Registered RAM read data lands in the DONE slot, when the ack is shown
  assign wb_dat_o = ram_q;
  assign vid_dat  = ram_q;

endmodule
`default_nettype wire
